// File: rtl/instruction_fetcher.sv
// instruction_fetcher
//   Per-SIMD fetch stage that sits directly after the SIMD program counter.
//   When the SIMD enters FETCH, this block copies the PC into a registered read
//   address and issues one valid/ready read to program memory. It latches the
//   returned instruction, holds it for the decoder, and reports its progress on
//   fetcher_state_o so the SIMD scheduler knows when to advance to DECODE.
//
// Ports
//   clk_i                  clock; all state changes on the rising edge
//   rst_i                  synchronous reset, active low
//   enable_i               0 = freeze all state and outputs, 1 = operate
//   simd_state_i  [2:0]    SIMD state (FETCH = 3'b001, DECODE = 3'b010)
//   dispatch_new_wave_i    new wave dispatched; aborts the fetch in progress
//   pc_i          [A-1:0]  fetch address from the PC stage
//   mem_read_valid_o       read request valid
//   mem_read_address_o     read address, stable while the request is valid
//   mem_read_ready_i       memory accepts the request and returns data this cycle
//   mem_read_data_i [D-1:0] instruction word, sampled on valid & ready
//   fetcher_state_o [2:0]  IDLE = 000, FETCHING = 001, FETCHED = 010
//   instruction_o [D-1:0]  last successfully fetched instruction

module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
  parameter int PROGRAM_MEM_DATA_WIDTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              enable_i,
  input  logic [2:0]                        simd_state_i,
  input  logic                              dispatch_new_wave_i,
  input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_i,
  output logic                              mem_read_valid_o,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] mem_read_address_o,
  input  logic                              mem_read_ready_i,
  input  logic [PROGRAM_MEM_DATA_WIDTH-1:0] mem_read_data_i,
  output logic [2:0]                        fetcher_state_o,
  output logic [PROGRAM_MEM_DATA_WIDTH-1:0] instruction_o
);

  localparam logic [2:0] SIMD_FETCH  = 3'b001;
  localparam logic [2:0] SIMD_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } fetch_state_e;

  fetch_state_e                      state_q;
  logic                              valid_q;
  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] address_q;
  logic [PROGRAM_MEM_DATA_WIDTH-1:0] instruction_q;
  // Remembers that a new wave was dispatched while the request was still
  // stalled; the request cannot be withdrawn, so its data is dropped instead.
  logic                              abort_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      valid_q       <= 1'b0;
      address_q     <= '0;
      instruction_q <= '0;
      abort_q       <= 1'b0;
    end else if (enable_i) begin
      case (state_q)
        IDLE: begin
          // A wave dispatch takes priority over starting a fetch for the old wave.
          if (!dispatch_new_wave_i && simd_state_i == SIMD_FETCH) begin
            valid_q   <= 1'b1;
            address_q <= pc_i;
            state_q   <= FETCHING;
          end
        end

        FETCHING: begin
          if (mem_read_ready_i) begin
            valid_q <= 1'b0;
            if (abort_q || dispatch_new_wave_i) begin
              abort_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              instruction_q <= mem_read_data_i;
              state_q       <= FETCHED;
            end
          end else if (dispatch_new_wave_i) begin
            abort_q <= 1'b1;
          end
        end

        FETCHED: begin
          // Staying in FETCHED while simd_state is still FETCH prevents a re-fetch.
          if (simd_state_i == SIMD_DECODE || dispatch_new_wave_i) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          abort_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_valid_o   = valid_q;
  assign mem_read_address_o = address_q;
  assign fetcher_state_o    = state_q;
  assign instruction_o      = instruction_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher
//   Self-checking bench for instruction_fetcher. Directed sequences cover reset,
//   zero-wait and stalled fetches, abort, enable freeze and back-to-back fetches;
//   a randomized phase follows. Expected outputs come from a transaction-level
//   model: a queue of outstanding read requests (each marked killed or not) plus
//   a "holding an instruction for decode" flag.

module tb_instruction_fetcher;

  localparam int A = 32;
  localparam int D = 16;
  localparam logic [2:0] FETCH  = 3'b001;
  localparam logic [2:0] DECODE = 3'b010;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [2:0]   simdState;
  logic         dnw;
  logic [A-1:0] pc;
  logic         memValid;
  logic [A-1:0] memAddress;
  logic         memReady;
  logic [D-1:0] memData;
  logic [2:0]   fetcherState;
  logic [D-1:0] instruction;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  instruction_fetcher #(
    .PROGRAM_MEM_ADDR_WIDTH(A),
    .PROGRAM_MEM_DATA_WIDTH(D)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .enable_i           (enable),
    .simd_state_i       (simdState),
    .dispatch_new_wave_i(dnw),
    .pc_i               (pc),
    .mem_read_valid_o   (memValid),
    .mem_read_address_o (memAddress),
    .mem_read_ready_i   (memReady),
    .mem_read_data_i    (memData),
    .fetcher_state_o    (fetcherState),
    .instruction_o      (instruction)
  );

  // Reference model: outstanding requests and decode-hold status.
  typedef struct {
    logic [A-1:0] addr;
    bit           killed;
  } request_t;

  request_t     reqQ[$];
  bit           holding;
  logic [A-1:0] lastAddr;
  logic [D-1:0] heldInstr;

  function automatic logic [D-1:0] programWord(input logic [A-1:0] addr);
    return addr[15:0] * 16'd40503 + 16'h3C5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep(input logic r, input logic en, input logic [2:0] ss,
                           input logic nw, input logic [A-1:0] p,
                           input logic rdy, input logic [D-1:0] data);
    request_t req;
    if (!r) begin
      reqQ.delete();
      holding   = 0;
      lastAddr  = '0;
      heldInstr = '0;
    end else if (en) begin
      if (reqQ.size() != 0) begin
        if (rdy) begin
          if (!reqQ[0].killed && !nw) begin
            heldInstr = data;
            holding   = 1;
          end
          void'(reqQ.pop_front());
        end else if (nw) begin
          reqQ[0].killed = 1;
        end
      end else if (holding) begin
        if (ss == DECODE || nw) holding = 0;
      end else if (ss == FETCH && !nw) begin
        req.addr   = p;
        req.killed = 0;
        reqQ.push_back(req);
        lastAddr = p;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic [2:0] ss,
                               input logic nw, input logic [A-1:0] p,
                               input logic rdy, input logic [D-1:0] data);
    logic [2:0] expState;
    rst       = r;
    enable    = en;
    simdState = ss;
    dnw       = nw;
    pc        = p;
    memReady  = rdy;
    memData   = data;
    @(posedge clk);
    modelStep(r, en, ss, nw, p, rdy, data);
    #1;
    expState = (reqQ.size() != 0) ? 3'b001 : (holding ? 3'b010 : 3'b000);
    checkOutput("state", {29'd0, fetcherState}, {29'd0, expState});
    checkOutput("valid", {31'd0, memValid}, {31'd0, reqQ.size() != 0});
    checkOutput("address", memAddress, lastAddr);
    checkOutput("instruction", {16'd0, instruction}, {16'd0, heldInstr});
  endtask

  initial begin
    logic [D-1:0] oldInstr;

    // Reset with random inputs.
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b0, 1'($urandom), 3'($urandom), 1'($urandom), $urandom,
                    1'($urandom), 16'($urandom));
    checkOutput("reset_state", {29'd0, fetcherState}, 32'd0);
    checkOutput("reset_valid", {31'd0, memValid}, 32'd0);
    checkOutput("reset_instr", {16'd0, instruction}, 32'd0);

    // Zero-wait fetch.
    applyStimulus(1, 1, FETCH, 0, 32'd5, 0, 16'h0000);
    checkOutput("zw_valid", {31'd0, memValid}, 32'd1);
    checkOutput("zw_addr", memAddress, 32'd5);
    applyStimulus(1, 1, FETCH, 0, 32'd5, 1, 16'hA1B2);
    checkOutput("zw_state", {29'd0, fetcherState}, 32'd2);
    checkOutput("zw_instr", {16'd0, instruction}, 32'h0000A1B2);
    applyStimulus(1, 1, FETCH, 0, 32'd5, 0, 16'h0000);
    checkOutput("zw_hold", {29'd0, fetcherState}, 32'd2);
    applyStimulus(1, 1, DECODE, 0, 32'd6, 0, 16'h0000);
    checkOutput("zw_idle", {29'd0, fetcherState}, 32'd0);

    // Stalled memory for four cycles.
    applyStimulus(1, 1, FETCH, 0, 32'h1234_5678, 0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, FETCH, 0, 32'($urandom), 0, 16'($urandom));
      checkOutput("stall_valid", {31'd0, memValid}, 32'd1);
      checkOutput("stall_addr", memAddress, 32'h1234_5678);
      checkOutput("stall_instr", {16'd0, instruction}, 32'h0000A1B2);
    end
    applyStimulus(1, 1, FETCH, 0, 32'd0, 1, 16'h0BAD);
    checkOutput("stall_capture", {16'd0, instruction}, 32'h00000BAD);
    applyStimulus(1, 1, DECODE, 0, 32'd0, 0, 16'h0000);

    // Abort during a stalled fetch.
    applyStimulus(1, 1, FETCH, 0, 32'h0000_0040, 0, 16'h0000);
    applyStimulus(1, 1, FETCH, 1, 32'h0000_0040, 0, 16'h0000);
    applyStimulus(1, 1, FETCH, 0, 32'h0000_0040, 0, 16'h0000);
    checkOutput("abort_valid", {31'd0, memValid}, 32'd1);
    applyStimulus(1, 1, FETCH, 0, 32'h0000_0040, 1, 16'hFFFF);
    checkOutput("abort_instr", {16'd0, instruction}, 32'h00000BAD);
    checkOutput("abort_state", {29'd0, fetcherState}, 32'd0);
    checkOutput("abort_valid_low", {31'd0, memValid}, 32'd0);

    // Enable low mid-fetch while memory is ready.
    applyStimulus(1, 1, FETCH, 0, 32'h0000_0077, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, DECODE, 0, 32'($urandom), 1, 16'h1357);
      checkOutput("freeze_state", {29'd0, fetcherState}, 32'd1);
      checkOutput("freeze_instr", {16'd0, instruction}, 32'h00000BAD);
    end
    applyStimulus(1, 1, FETCH, 0, 32'd0, 1, 16'h1357);
    checkOutput("freeze_capture", {16'd0, instruction}, 32'h00001357);
    applyStimulus(1, 1, DECODE, 0, 32'd0, 0, 16'h0000);

    // Back-to-back fetches of addresses 0 and 1.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, FETCH, 0, 32'(k), 0, 16'h0000);
      checkOutput("b2b_addr", memAddress, 32'(k));
      applyStimulus(1, 1, FETCH, 0, 32'(k), 1, programWord(32'(k)));
      checkOutput("b2b_instr", {16'd0, instruction}, {16'd0, programWord(32'(k))});
      applyStimulus(1, 1, DECODE, 0, 32'(k), 0, 16'h0000);
    end

    // Randomized traffic; memory answers with the word at the pending address.
    for (int i = 0; i < 2000; i++) begin
      oldInstr = programWord(lastAddr);
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                    3'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                    $urandom, 1'($urandom), oldInstr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
